// File: rtl/sigma_delta_demod_top.sv
`default_nettype none
// ============================================================================
// Module   : sigma_delta_demod_top
// Purpose  : Receive-side demodulator for a 1-bit sigma-delta bitstream.
//            The serial input is synchronised and decimated by a sinc1 (boxcar)
//            filter over R = 2**LOG2_DECIM bits. Each decimated sample is
//            exposed to the CPU through an AXI4-Lite slave register file.
// Ports    : aclk, aresetn (async, active low)
//            AXI4-Lite slave: aw*/w*/b* write channels, ar*/r* read channels
//            sigma_delta : asynchronous 1-bit modulated input
// Registers: 0x0 CTRL (bit0 en), 0x4 SAMPLE (RO), 0x8 STATUS (bit0 valid,
//            bit1 overrun), 0xC reads 0
// Option   : SD_DEMOD_OVERRUN_EN - builds the sticky STATUS.overrun flag,
//            cleared by writing 1 to STATUS bit1.
// Revision : 1.0 - initial release
// ============================================================================
module sigma_delta_demod_top #(
  parameter int LOG2_DECIM = 4
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] awaddr,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [31:0] araddr,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic        sigma_delta
);

  localparam int SW = LOG2_DECIM + 1;
  localparam logic [1:0] C_ADDR_CTRL   = 2'd0;
  localparam logic [1:0] C_ADDR_SAMPLE = 2'd1;
  localparam logic [1:0] C_ADDR_STATUS = 2'd2;
  localparam logic [LOG2_DECIM-1:0] C_CNT_LAST = '1;

  logic                  sd_meta_q, sd_meta_d;
  logic                  sd_sync_q, sd_sync_d;
  logic                  en_q, en_d;
  logic [LOG2_DECIM-1:0] cnt_q, cnt_d;
  logic [SW-1:0]         acc_q, acc_d;
  logic [SW-1:0]         sample_q, sample_d;
  logic                  valid_q, valid_d;
  logic                  bvalid_q, bvalid_d;
  logic                  rvalid_q, rvalid_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  rd_sample_q, rd_sample_d;

  logic                  w_wr_fire;
  logic                  w_wr_lane0;
  logic                  w_rd_fire;
  logic                  w_run;
  logic                  w_last;
  logic                  w_rd_clear;
  logic                  w_ovr;
  logic [31:0]           w_rd_mux;

`ifdef SD_DEMOD_OVERRUN_EN
  logic                  ovr_q, ovr_d;
  assign w_ovr = ovr_q;
`else
  assign w_ovr = 1'b0;
`endif

  always_comb begin
    // Both ready strobes are gated by reset so the bus sees them low during reset.
    w_wr_fire  = aresetn & awvalid & wvalid & ~bvalid_q;
    w_wr_lane0 = w_wr_fire & wstrb[0];
    w_rd_fire  = aresetn & arvalid & ~rvalid_q;

    sd_meta_d = sigma_delta;
    sd_sync_d = sd_meta_q;

    en_d = en_q;
    if (w_wr_lane0 && (awaddr[3:2] == C_ADDR_CTRL)) begin
      en_d = wdata[0];
    end

    // The filter advances only while enabled both before and after this edge:
    // a disable clears the window on the write edge itself, and an enable
    // starts counting on the following edge so a window ends R clocks later.
    w_run  = en_q & en_d;
    w_last = w_run & (cnt_q == C_CNT_LAST);

    cnt_d    = w_run ? (cnt_q + LOG2_DECIM'(1)) : '0;
    acc_d    = (w_run && !w_last) ? (acc_q + SW'(sd_sync_q)) : '0;
    sample_d = w_last ? (acc_q + SW'(sd_sync_q)) : sample_q;

    // A landing sample beats the clear-on-read of SAMPLE.
    w_rd_clear = rvalid_q & rready & rd_sample_q;
    valid_d    = valid_q;
    if (w_rd_clear) valid_d = 1'b0;
    if (w_last)     valid_d = 1'b1;

`ifdef SD_DEMOD_OVERRUN_EN
    ovr_d = ovr_q;
    if (w_wr_lane0 && (awaddr[3:2] == C_ADDR_STATUS) && wdata[1]) ovr_d = 1'b0;
    if (w_last && valid_q) ovr_d = 1'b1;
`endif

    case (araddr[3:2])
      C_ADDR_CTRL:   w_rd_mux = {31'd0, en_q};
      C_ADDR_SAMPLE: w_rd_mux = {{(32-SW){1'b0}}, sample_q};
      C_ADDR_STATUS: w_rd_mux = {30'd0, w_ovr, valid_q};
      default:       w_rd_mux = 32'd0;
    endcase

    rvalid_d    = rvalid_q;
    rdata_d     = rdata_q;
    rd_sample_d = rd_sample_q;
    if (rvalid_q && rready) rvalid_d = 1'b0;
    if (w_rd_fire) begin
      rvalid_d    = 1'b1;
      rdata_d     = w_rd_mux;
      rd_sample_d = (araddr[3:2] == C_ADDR_SAMPLE);
    end

    bvalid_d = bvalid_q;
    if (bvalid_q && bready) bvalid_d = 1'b0;
    if (w_wr_fire)          bvalid_d = 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sd_meta_q   <= 1'b0;
      sd_sync_q   <= 1'b0;
      en_q        <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      sample_q    <= '0;
      valid_q     <= 1'b0;
      bvalid_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= 32'd0;
      rd_sample_q <= 1'b0;
`ifdef SD_DEMOD_OVERRUN_EN
      ovr_q       <= 1'b0;
`endif
    end else begin
      sd_meta_q   <= sd_meta_d;
      sd_sync_q   <= sd_sync_d;
      en_q        <= en_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      sample_q    <= sample_d;
      valid_q     <= valid_d;
      bvalid_q    <= bvalid_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rd_sample_q <= rd_sample_d;
`ifdef SD_DEMOD_OVERRUN_EN
      ovr_q       <= ovr_d;
`endif
    end
  end

  assign awready = w_wr_fire;
  assign wready  = w_wr_fire;
  assign bresp   = 2'b00;
  assign bvalid  = bvalid_q;
  assign arready = w_rd_fire;
  assign rdata   = rdata_q;
  assign rresp   = 2'b00;
  assign rvalid  = rvalid_q;

  // Bus fields this register file does not decode.
  logic unused_ok;
`ifdef SD_DEMOD_OVERRUN_EN
  assign unused_ok = &{1'b0, awprot, arprot, awaddr[31:4], awaddr[1:0],
                       araddr[31:4], araddr[1:0], wdata[31:2], wstrb[3:1]};
`else
  assign unused_ok = &{1'b0, awprot, arprot, awaddr[31:4], awaddr[1:0],
                       araddr[31:4], araddr[1:0], wdata[31:1], wstrb[3:1]};
`endif

endmodule
`default_nettype wire
